// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer widths, depth, arbitration limit and fill FSM encoding
package fb_pkg;
  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 32;
  localparam int FB_WORDS = 32768;
  localparam int DEF_STARVE_MAX = 4;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fill_state_t;
endpackage

// File: rtl/fb_fill_engine.sv
// fb_fill_engine: fill FSM with address/remaining counters and busy/done flags
module fb_fill_engine import fb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int FB_DEPTH = FB_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [15:0]       fill_len,
  input  logic [DATA_W-1:0] fill_pattern,
  input  logic              fill_abort,
  input  logic              fill_grant,
  input  logic              out_fill,
  input  logic              fb_ready,
  output logic              fill_req,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_busy,
  output logic              fill_done
);
  fill_state_t state;
  logic [15:0] remaining;
  logic [ADDR_W-1:0] next_addr;
  assign fill_req = state == RUN;
  assign next_addr = fill_addr == ADDR_W'(FB_DEPTH - 1) ? '0 : fill_addr + 1'b1;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      remaining <= '0;
      fill_addr <= '0;
      fill_data <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
    end else
      case (state)
        IDLE: if (fill_start) begin
          fill_addr <= fill_base;
          fill_data <= fill_pattern;
          remaining <= fill_len;
          state <= fill_len != '0 ? RUN : DONE;
          fill_busy <= 1'b1;
          fill_done <= fill_len == '0;
        end
        RUN: begin
          if (fill_grant) begin
            fill_addr <= next_addr;
            remaining <= remaining - 1'b1;
          end
          if (fill_abort || (fill_grant && remaining == 16'd1)) state <= DRAIN;
        end
        DRAIN: if (!out_fill || fb_ready) begin
          state <= DONE;
          fill_done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          fill_busy <= 1'b0;
          fill_done <= 1'b0;
        end
      endcase
endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: shares the framebuffer write port between CPU stores and the fill engine
module fb_write_arbiter import fb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int FB_DEPTH = FB_WORDS,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              cpu_clk,
  input  logic              sys_rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_w_en,
  output logic              cpu_ready,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [15:0]       fill_len,
  input  logic [DATA_W-1:0] fill_pattern,
  input  logic              fill_abort,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              fb_w_en,
  input  logic              fb_ready
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic load_en, fill_req, fill_win, cpu_grant, fill_grant, out_fill;
  logic [SW-1:0] starve_cnt;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  assign load_en = !fb_w_en | fb_ready;
  assign fill_win = fill_req & (!cpu_w_en | starve_cnt == SW'(STARVE_MAX));
  assign cpu_grant = load_en & cpu_w_en & !fill_win;
  assign fill_grant = load_en & fill_win;
  assign cpu_ready = cpu_grant;
  fb_fill_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_DEPTH(FB_DEPTH)) u_fill (
    .clk(cpu_clk),
    .rst(sys_rst),
    .fill_start(fill_start),
    .fill_base(fill_base),
    .fill_len(fill_len),
    .fill_pattern(fill_pattern),
    .fill_abort(fill_abort),
    .fill_grant(fill_grant),
    .out_fill(out_fill),
    .fb_ready(fb_ready),
    .fill_req(fill_req),
    .fill_addr(fill_addr),
    .fill_data(fill_data),
    .fill_busy(fill_busy),
    .fill_done(fill_done)
  );
  always_ff @(posedge cpu_clk)
    if (sys_rst) begin
      fb_w_en <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
      out_fill <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (load_en) begin
        fb_w_en <= cpu_grant | fill_grant;
        out_fill <= fill_grant;
        if (cpu_grant | fill_grant) begin
          fb_addr <= fill_grant ? fill_addr : cpu_addr;
          fb_data <= fill_grant ? fill_data : cpu_data;
        end
      end
      starve_cnt <= !fill_req || fill_grant ? '0 : cpu_grant ? starve_cnt + 1'b1 : starve_cnt;
    end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: scoreboard bench for the framebuffer write arbiter
module tb_fb_write_arbiter;
  typedef struct packed {logic [14:0] a; logic [31:0] d;} beat_t;
  logic cpu_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic [14:0] cpu_addr = '0;
  logic [31:0] cpu_data = '0;
  logic cpu_w_en = 1'b0;
  logic cpu_ready;
  logic fill_start = 1'b0;
  logic [14:0] fill_base = '0;
  logic [15:0] fill_len = '0;
  logic [31:0] fill_pattern = '0;
  logic fill_abort = 1'b0;
  logic fill_busy, fill_done;
  logic [14:0] fb_addr;
  logic [31:0] fb_data;
  logic fb_w_en;
  logic fb_ready = 1'b1;
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  beat_t exp_q[$];
  always #5 cpu_clk = ~cpu_clk;
  fb_write_arbiter dut (
    .cpu_clk(cpu_clk), .sys_rst(sys_rst),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_w_en(cpu_w_en), .cpu_ready(cpu_ready),
    .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
    .fill_pattern(fill_pattern), .fill_abort(fill_abort),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_w_en(fb_w_en), .fb_ready(fb_ready)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge cpu_clk);
    #1;
  endtask
  task automatic push(input logic [14:0] a, input logic [31:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask
  task automatic start_fill(input logic [14:0] b, input logic [15:0] l, input logic [31:0] p);
    fill_base = b;
    fill_len = l;
    fill_pattern = p;
    fill_start = 1'b1;
    tick;
    fill_start = 1'b0;
    fill_base = 15'h1234;
    fill_len = 16'd7;
    fill_pattern = 32'hBAD0BAD0;
  endtask
  task automatic wait_done(input int maxc, output int n);
    n = 0;
    while (!fill_done && n < maxc) begin
      tick;
      n++;
    end
    check("fill_done_seen", 64'(fill_done), 64'd1);
  endtask
  task automatic after_done(input string name, input int d0);
    tick;
    check({name, "_done_pulse"}, 64'(fill_done), 64'd0);
    check({name, "_busy_low"}, 64'(fill_busy), 64'd0);
    check({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask
  initial begin
    int n, k, d0;
    logic acc;
    fork
      begin : monitor
        logic hold;
        beat_t held, e;
        hold = 1'b0;
        held = '0;
        forever begin
          @(negedge cpu_clk);
          if (hold && fb_w_en) check("stall_stable", 64'({fb_addr, fb_data}), 64'(held));
          if (fb_w_en && fb_ready) begin
            if (exp_q.size() == 0) check("unexpected_beat", 64'({fb_addr, fb_data}), 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
              e = exp_q.pop_front();
              check("beat", 64'({fb_addr, fb_data}), 64'(e));
            end
          end
          hold = fb_w_en && !fb_ready;
          held = '{a: fb_addr, d: fb_data};
          if (fill_done) done_cnt++;
        end
      end
    join_none
    tick;
    tick;
    check("rst_w_en", 64'(fb_w_en), 64'd0);
    check("rst_addr_data", 64'({fb_addr, fb_data}), 64'd0);
    check("rst_busy_done", 64'({fill_busy, fill_done}), 64'd0);
    sys_rst = 1'b0;
    tick;
    cpu_addr = 15'h0010;
    cpu_data = 32'hDEADBEEF;
    cpu_w_en = 1'b1;
    push(15'h0010, 32'hDEADBEEF);
    #1;
    check("t1_cpu_ready", 64'(cpu_ready), 64'd1);
    tick;
    cpu_w_en = 1'b0;
    check("t1_out", 64'({fb_w_en, fb_addr, fb_data}), {16'd0, 1'b1, 15'h0010, 32'hDEADBEEF});
    tick;
    check("t1_w_en_clear", 64'(fb_w_en), 64'd0);
    d0 = done_cnt;
    push(15'h7FFE, 32'h00FF00FF);
    push(15'h7FFF, 32'h00FF00FF);
    push(15'h0000, 32'h00FF00FF);
    push(15'h0001, 32'h00FF00FF);
    start_fill(15'h7FFE, 16'd4, 32'h00FF00FF);
    check("t2_busy", 64'(fill_busy), 64'd1);
    wait_done(30, n);
    check("t2_done_latency", 64'(n), 64'd5);
    after_done("t2", d0);
    d0 = done_cnt;
    push(15'h4000, 32'hC0DE0000);
    for (int f = 0; f < 100; f++) begin
      for (int j = 1; j <= 4; j++) push(15'h4000 + 15'(4 * f + j), 32'hC0DE0000 + 32'(4 * f + j));
      push(15'h0100 + 15'(f), 32'hA5A50000);
    end
    fill_base = 15'h0100;
    fill_len = 16'd100;
    fill_pattern = 32'hA5A50000;
    fill_start = 1'b1;
    k = 0;
    for (int c = 0; c < 2000 && k < 401; c++) begin
      cpu_w_en = 1'b1;
      cpu_addr = 15'h4000 + 15'(k);
      cpu_data = 32'hC0DE0000 + 32'(k);
      #1;
      acc = cpu_ready;
      tick;
      fill_start = 1'b0;
      fill_pattern = 32'h0;
      if (acc) k++;
    end
    cpu_w_en = 1'b0;
    check("t3_cpu_beats", 64'(k), 64'd401);
    wait_done(30, n);
    after_done("t3", d0);
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) push(15'h0200 + 15'(i), 32'h12345678);
    start_fill(15'h0200, 16'd8, 32'h12345678);
    n = 0;
    while (!fill_done && n < 100) begin
      fb_ready = (n % 3) == 0;
      tick;
      n++;
    end
    check("t4_fill_done_seen", 64'(fill_done), 64'd1);
    fb_ready = 1'b1;
    after_done("t4", d0);
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) push(15'h0300 + 15'(i), 32'hCAFEF00D);
    start_fill(15'h0300, 16'd50, 32'hCAFEF00D);
    tick;
    tick;
    fill_abort = 1'b1;
    tick;
    fill_abort = 1'b0;
    wait_done(30, n);
    after_done("t5_abort", d0);
    repeat (3) tick;
    check("t5_no_extra", 64'(fb_w_en), 64'd0);
    d0 = done_cnt;
    start_fill(15'h0500, 16'd0, 32'h11111111);
    check("t5_len0_done", 64'({fill_done, fill_busy, fb_w_en}), 64'b110);
    tick;
    check("t5_len0_after", 64'({fill_done, fill_busy, fb_w_en}), 64'b000);
    tick;
    check("t5_len0_done_count", 64'(done_cnt - d0), 64'd1);
    d0 = done_cnt;
    start_fill(15'h0400, 16'd20, 32'h55AA55AA);
    fb_ready = 1'b0;
    tick;
    check("t6_in_flight", 64'({fb_w_en, fb_addr}), {48'd0, 1'b1, 15'h0400});
    sys_rst = 1'b1;
    tick;
    sys_rst = 1'b0;
    fb_ready = 1'b1;
    check("t6_rst_out", 64'({fb_w_en, fb_addr, fb_data}), 64'd0);
    check("t6_rst_flags", 64'({fill_busy, fill_done}), 64'd0);
    repeat (4) tick;
    check("t6_no_done", 64'(done_cnt - d0), 64'd0);
    check("t6_idle", 64'({fb_w_en, fill_busy}), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
